// File: rtl/iter_div.sv
// Multi-cycle restoring unsigned divider, BITS_PER_CYCLE quotient bits per RUN cycle.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips RUN and completes in one cycle.
module iter_div #(
  parameter int WIDTH          = 51,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (WIDTH % BITS_PER_CYCLE) != 0 || WIDTH < 2) begin : g_bad_param
      $error("iter_div: illegal WIDTH/BITS_PER_CYCLE combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [WIDTH-1:0]  r_a, r_d;
  logic [WIDTH:0]    r_p;
  logic [CW-1:0]     r_cnt;
  logic              w_zero;
  logic [WIDTH-1:0]  w_a_step;
  logic [WIDTH:0]    w_p_step, w_t;

  assign w_zero = (divisor == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef DIV_ZERO_BYPASS_EN
          w_state_next = w_zero ? S_DONE : S_RUN;
`else
          w_state_next = S_RUN;
`endif
        end
      end
      S_RUN:   if (r_cnt == LAST_CNT) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decode the state register only, so no input reaches them combinationally.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // The extra top bit of t acts as the borrow: set means p < d, so restore.
  always_comb begin
    w_p_step = r_p;
    w_a_step = r_a;
    w_t      = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      w_p_step = {w_p_step[WIDTH-1:0], w_a_step[WIDTH-1]};
      w_a_step = w_a_step << 1;
      w_t      = w_p_step - {1'b0, r_d};
      if (!w_t[WIDTH]) begin
        w_p_step    = w_t;
        w_a_step[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_d         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a         <= dividend;
            r_d         <= divisor;
            r_p         <= '0;
            r_cnt       <= '0;
            div_by_zero <= w_zero;
`ifdef DIV_ZERO_BYPASS_EN
            if (w_zero) begin
              quotient  <= '1;
              remainder <= dividend;
            end
`endif
          end
        end
        S_RUN: begin
          r_a   <= w_a_step;
          r_p   <= w_p_step;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            quotient  <= w_a_step;
            remainder <= w_p_step[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: WIDTH=8 at 1 and 2 bits/cycle, plus default WIDTH=51.
module tb_iter_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

`ifdef DIV_ZERO_BYPASS_EN
  localparam int LAT_Z_A = 1;
  localparam int LAT_Z_B = 1;
`else
  localparam int LAT_Z_A = 8;
  localparam int LAT_Z_B = 4;
`endif

  logic       a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_z;
  logic [7:0] a_dividend = 0, a_divisor = 0, a_q, a_r;
  logic       b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_z;
  logic [7:0] b_dividend = 0, b_divisor = 0, b_q, b_r;
  logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_z;
  logic [50:0] c_dividend = 0, c_divisor = 0, c_q, c_r;

  iter_div #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .dividend(a_dividend), .divisor(a_divisor), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .quotient(a_q), .remainder(a_r), .div_by_zero(a_z));

  iter_div #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dividend(b_dividend), .divisor(b_divisor), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .quotient(b_q), .remainder(b_r), .div_by_zero(b_z));

  iter_div u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .dividend(c_dividend), .divisor(c_divisor), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .quotient(c_q), .remainder(c_r), .div_by_zero(c_z));

  // Drives one operation into DUT a (sel=0) or b (sel=1); returns result and latency.
  task automatic op8(input int sel, input logic [7:0] x, input logic [7:0] y, input bit release_out,
                     output logic [7:0] q, output logic [7:0] r, output logic z, output int lat);
    logic v;
    @(negedge clk);
    if (sel == 0) begin a_dividend = x; a_divisor = y; a_in_valid = 1; end
    else          begin b_dividend = x; b_divisor = y; b_in_valid = 1; end
    @(posedge clk); #1;
    a_in_valid = 0; b_in_valid = 0;
    lat = 0;
    v = 0;
    while (!v && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      v = (sel == 0) ? a_out_valid : b_out_valid;
    end
    if (!v) begin
      checks++; errors++;
      $display("FAIL op8_timeout: out_valid never rose, sel=%0d %0d/%0d", sel, x, y);
    end
    q = (sel == 0) ? a_q : b_q;
    r = (sel == 0) ? a_r : b_r;
    z = (sel == 0) ? a_z : b_z;
    if (release_out && v) begin
      @(negedge clk);
      a_out_ready = (sel == 0); b_out_ready = (sel == 1);
      @(posedge clk); #1;
      a_out_ready = 0; b_out_ready = 0;
    end
  endtask

  task automatic op51(input logic [50:0] x, input logic [50:0] y,
                      output logic [50:0] q, output logic [50:0] r, output int lat);
    @(negedge clk);
    c_dividend = x; c_divisor = y; c_in_valid = 1;
    @(posedge clk); #1;
    c_in_valid = 0;
    lat = 0;
    while (!c_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!c_out_valid) begin
      checks++; errors++;
      $display("FAIL op51_timeout: out_valid never rose for %0d/%0d", x, y);
    end
    q = c_q; r = c_r;
    @(negedge clk);
    c_out_ready = 1;
    @(posedge clk); #1;
    c_out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_q !== 8'd0 || a_r !== 8'd0 || a_z !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got q=%0d r=%0d z=%b want 0 0 0", a_q, a_r, a_z); end
    checks++; if (c_out_valid !== 1'b0 || c_q !== '0 || c_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wide: got ov=%b q=%0d ir=%b want 0 0 1", c_out_valid, c_q, c_in_ready); end
  endtask

  task automatic test_bpc1();
    logic [7:0] q, r; logic z; int lat;
    op8(0, 8'd200, 8'd7, 1, q, r, z, lat);
    checks++; if (q !== 8'd28) begin errors++; $display("FAIL bpc1_q: got %0d want 28", q); end
    checks++; if (r !== 8'd4) begin errors++; $display("FAIL bpc1_r: got %0d want 4", r); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL bpc1_dbz: got %b want 0", z); end
    checks++; if (lat != 8) begin errors++; $display("FAIL bpc1_latency: got %0d want 8", lat); end
  endtask

  task automatic test_bpc2();
    logic [7:0] q, r; logic z; int lat;
    op8(1, 8'd255, 8'd1, 1, q, r, z, lat);
    checks++; if (q !== 8'd255 || r !== 8'd0) begin errors++; $display("FAIL bpc2_255_1: got %0d r %0d want 255 r 0", q, r); end
    checks++; if (lat != 4) begin errors++; $display("FAIL bpc2_latency: got %0d want 4", lat); end
    op8(1, 8'd5, 8'd9, 1, q, r, z, lat);
    checks++; if (q !== 8'd0 || r !== 8'd5) begin errors++; $display("FAIL bpc2_5_9: got %0d r %0d want 0 r 5", q, r); end
    op8(1, 8'h80, 8'h81, 1, q, r, z, lat);
    checks++; if (q !== 8'h00 || r !== 8'h80) begin errors++; $display("FAIL bpc2_msb_guard: got %0d r %0d want 0 r 128", q, r); end
    op8(1, 8'd187, 8'd13, 1, q, r, z, lat);
    checks++; if (q !== 8'd14 || r !== 8'd5) begin errors++; $display("FAIL bpc2_187_13: got %0d r %0d want 14 r 5", q, r); end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r; logic z; int lat;
    op8(0, 8'hA5, 8'h00, 1, q, r, z, lat);
    checks++; if (q !== 8'hFF || r !== 8'hA5) begin errors++; $display("FAIL dz_a_values: got %0d r %0d want 255 r 165", q, r); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL dz_a_flag: got %b want 1", z); end
    checks++; if (lat != LAT_Z_A) begin errors++; $display("FAIL dz_a_latency: got %0d want %0d", lat, LAT_Z_A); end
    op8(1, 8'h3C, 8'h00, 1, q, r, z, lat);
    checks++; if (q !== 8'hFF || r !== 8'h3C || z !== 1'b1) begin
      errors++; $display("FAIL dz_b_values: got %0d r %0d z %b want 255 r 60 z 1", q, r, z); end
    checks++; if (lat != LAT_Z_B) begin errors++; $display("FAIL dz_b_latency: got %0d want %0d", lat, LAT_Z_B); end
    op8(0, 8'd9, 8'd3, 1, q, r, z, lat);
    checks++; if (q !== 8'd3 || r !== 8'd0 || z !== 1'b0) begin
      errors++; $display("FAIL dz_clear: got %0d r %0d z %b want 3 r 0 z 0", q, r, z); end
  endtask

  task automatic test_backpressure();
    logic [7:0] q, r; logic z; int lat;
    op8(0, 8'd100, 8'd7, 0, q, r, z, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_in_valid = i[0]; a_dividend = 8'h11; a_divisor = 8'h01;
      @(posedge clk); #1;
      checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: got ov=%b ir=%b want 1 0", i, a_out_valid, a_in_ready); end
      checks++; if (a_q !== 8'd14 || a_r !== 8'd2) begin
        errors++; $display("FAIL bp_stable_%0d: got %0d r %0d want 14 r 2", i, a_q, a_r); end
    end
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 1;
    @(posedge clk); #1;
    a_out_ready = 0;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ir=%b ov=%b want 1 0", a_in_ready, a_out_valid); end
    @(posedge clk); #1;
    checks++; if (a_in_ready !== 1'b1 || a_q !== 8'd14 || a_r !== 8'd2) begin
      errors++; $display("FAIL bp_idle_hold: got ir=%b q=%0d r=%0d want 1 14 2", a_in_ready, a_q, a_r); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] q, r; logic z; int lat; bit seen;
    @(negedge clk);
    a_dividend = 8'd200; a_divisor = 8'd0; a_in_valid = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL rr_state: got ir=%b ov=%b want 1 0", a_in_ready, a_out_valid); end
    checks++; if (a_q !== 8'd0 || a_r !== 8'd0 || a_z !== 1'b0) begin
      errors++; $display("FAIL rr_outputs: got q=%0d r=%0d z=%b want 0 0 0", a_q, a_r, a_z); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rr_no_out_valid: got out_valid=1 want 0"); end
    op8(0, 8'd100, 8'd10, 1, q, r, z, lat);
    checks++; if (q !== 8'd10 || r !== 8'd0 || lat != 8) begin
      errors++; $display("FAIL rr_followup: got %0d r %0d lat %0d want 10 r 0 lat 8", q, r, lat); end
  endtask

  task automatic test_wide();
    logic [50:0] x, y, q, r, mask;
    logic [63:0] t64;
    longint unsigned ex, ey;
    int lat;
    mask = '1;
    for (int i = 0; i < 306; i++) begin
      t64 = {$urandom(), $urandom()};
      x = t64[50:0];
      t64 = {$urandom(), $urandom()};
      y = t64[50:0] >> $urandom_range(0, 50);
      case (i)
        0: y = 51'd1;
        1: begin x = mask; y = 51'd1; end
        2: y = mask;
        3: begin x = mask; y = mask; end
        4: begin x = 51'd0; y = 51'd5; end
        5: begin x = 51'h4_0000_0000_0000; y = 51'd3; end
        default: ;
      endcase
      if (y == 0) y = 51'd1;
      ex = 64'(x); ey = 64'(y);
      op51(x, y, q, r, lat);
      checks++; if (64'(q) != ex / ey) begin errors++; $display("FAIL wide_q[%0d]: %0d/%0d got %0d want %0d", i, x, y, q, ex / ey); end
      checks++; if (64'(r) != ex % ey) begin errors++; $display("FAIL wide_r[%0d]: %0d/%0d got %0d want %0d", i, x, y, r, ex % ey); end
      checks++; if (lat != 51) begin errors++; $display("FAIL wide_latency[%0d]: got %0d want 51", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_bpc1();
    test_bpc2();
    test_div_zero();
    test_backpressure();
    test_reset_mid_run();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
